// File: rtl/im_loader_pkg.sv
// im_loader_pkg: shared FSM state encoding and stream framing constants for the IM loader
package im_loader_pkg;
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_CHK, S_DONE, S_ERR} state_t;
  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/im_loader_word_assembler.sv
// im_loader_word_assembler: shifts in bytes LSB first and flags the byte that completes a word
module im_loader_word_assembler
  import im_loader_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic [7:0]        i_byte,
  output logic [DATA_W-1:0] o_word,
  output logic              o_word_ready
);
  localparam int BW = $clog2(BYTES_PER_WORD);
  logic [BW-1:0]       r_cnt;
  logic [DATA_W-9:0]   r_sh;
  assign o_word       = {i_byte, r_sh};
  assign o_word_ready = i_en & (r_cnt == BW'(BYTES_PER_WORD - 1));
  // byte counter wraps every word; newest byte enters at the top so the first byte ends up as LSB
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_cnt <= '0;
      r_sh  <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
      r_sh  <= o_word[DATA_W-1:8];
    end
endmodule

// File: rtl/im_loader.sv
// im_loader: byte-stream program loader driving the IM write port; IM_LOADER_CHECKSUM_EN adds a trailing 32-bit sum check
module im_loader
  import im_loader_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 64,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_byte_valid,
  input  logic [7:0]        i_byte_data,
  output logic              o_byte_ready,
  output logic              o_im_we,
  output logic [ADDR_W-1:0] o_im_waddr,
  output logic [DATA_W-1:0] o_im_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic              o_cpu_rst_hold
);
  localparam int CW = $clog2(DEPTH) + 1;
  state_t            r_state;
  logic              r_hcnt;
  logic [7:0]        r_nlo;
  logic [CW-1:0]     r_n;
  logic [CW-1:0]     r_idx;
`ifdef IM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] r_sum;
`endif
  logic              w_acc;
  logic              w_idle;
  logic              w_rdy;
  logic              w_wr;
  logic [15:0]       w_n16;
  logic [DATA_W-1:0] w_word;
  assign w_acc  = i_byte_valid & o_byte_ready;
  assign w_idle = (r_state == S_IDLE) | (r_state == S_DONE) | (r_state == S_ERR);
  assign w_wr   = w_rdy & (r_state == S_DATA);
  assign w_n16  = {i_byte_data, r_nlo};
  im_loader_word_assembler #(.DATA_W(DATA_W)) u_asm (
    .clk          (clk),
    .rst          (rst),
    .i_clr        (w_idle & i_start),
    .i_en         (w_acc & ((r_state == S_DATA) | (r_state == S_CHK))),
    .i_byte       (i_byte_data),
    .o_word       (w_word),
    .o_word_ready (w_rdy)
  );
  // load FSM; the IM strobe is registered so it lands one cycle after the completing byte
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state        <= S_IDLE;
      r_hcnt         <= 1'b0;
      r_nlo          <= '0;
      r_n            <= '0;
      r_idx          <= '0;
`ifdef IM_LOADER_CHECKSUM_EN
      r_sum          <= '0;
`endif
      o_byte_ready   <= 1'b0;
      o_im_we        <= 1'b0;
      o_im_waddr     <= '0;
      o_im_wdata     <= '0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_err          <= 1'b0;
      o_cpu_rst_hold <= 1'b1;
    end else begin
      o_im_we <= w_wr;
      if (w_wr) begin
        o_im_waddr <= ADDR_W'(r_idx) << 2;
        o_im_wdata <= w_word;
        r_idx      <= r_idx + 1'b1;
`ifdef IM_LOADER_CHECKSUM_EN
        r_sum      <= r_sum + w_word;
`endif
      end
      case (r_state)
        S_IDLE, S_DONE, S_ERR:
          if (i_start) begin
            r_state        <= S_HDR;
            r_hcnt         <= 1'b0;
            r_idx          <= '0;
`ifdef IM_LOADER_CHECKSUM_EN
            r_sum          <= '0;
`endif
            o_byte_ready   <= 1'b1;
            o_busy         <= 1'b1;
            o_done         <= 1'b0;
            o_err          <= 1'b0;
            o_cpu_rst_hold <= 1'b1;
          end
        S_HDR:
          if (w_acc) begin
            r_hcnt <= r_hcnt + 1'b1;
            r_nlo  <= i_byte_data;
            if (r_hcnt == 1'(HDR_BYTES - 1)) begin
              if (w_n16 == 16'd0 || w_n16 > 16'(DEPTH)) begin
                r_state      <= S_ERR;
                o_byte_ready <= 1'b0;
                o_busy       <= 1'b0;
                o_err        <= 1'b1;
              end else begin
                r_state <= S_DATA;
                r_n     <= CW'(w_n16);
              end
            end
          end
        S_DATA:
          if (w_wr && r_idx == r_n - CW'(1)) begin
`ifdef IM_LOADER_CHECKSUM_EN
            r_state        <= S_CHK;
`else
            r_state        <= S_DONE;
            o_byte_ready   <= 1'b0;
            o_busy         <= 1'b0;
            o_done         <= 1'b1;
            o_cpu_rst_hold <= 1'b0;
`endif
          end
`ifdef IM_LOADER_CHECKSUM_EN
        S_CHK:
          if (w_rdy) begin
            r_state        <= (w_word == r_sum) ? S_DONE : S_ERR;
            o_byte_ready   <= 1'b0;
            o_busy         <= 1'b0;
            o_done         <= (w_word == r_sum);
            o_err          <= (w_word != r_sum);
            o_cpu_rst_hold <= (w_word != r_sum);
          end
`endif
        default: ;
      endcase
    end
endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: directed self-checking bench for im_loader (define IM_LOADER_CHECKSUM_EN to cover the checksum build)
module tb_im_loader;
  localparam int ADDR_W = 16;
  localparam int DEPTH  = 64;
  localparam int DATA_W = 32;
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_start = 1'b0;
  logic              i_byte_valid = 1'b0;
  logic [7:0]        i_byte_data = 8'h00;
  logic              o_byte_ready;
  logic              o_im_we;
  logic [ADDR_W-1:0] o_im_waddr;
  logic [DATA_W-1:0] o_im_wdata;
  logic              o_busy;
  logic              o_done;
  logic              o_err;
  logic              o_cpu_rst_hold;
  int                n_tests = 0;
  int                n_fail  = 0;
  int                nw      = 0;
  logic [31:0]       sum;
  logic [31:0]       w;

  im_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_start        (i_start),
    .i_byte_valid   (i_byte_valid),
    .i_byte_data    (i_byte_data),
    .o_byte_ready   (o_byte_ready),
    .o_im_we        (o_im_we),
    .o_im_waddr     (o_im_waddr),
    .o_im_wdata     (o_im_wdata),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_err          (o_err),
    .o_cpu_rst_hold (o_cpu_rst_hold)
  );

  always #5 clk = ~clk;

  // counts IM write strobes, sampled just after each rising edge
  always @(posedge clk) begin
    #1;
    if (o_im_we === 1'b1) nw++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int k;
    i_byte_valid = 1'b1;
    i_byte_data  = b;
    k = 0;
    while (o_byte_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("ready_timeout", 32'(k < 20), 32'd1);
    @(negedge clk);
    i_byte_valid = 1'b0;
  endtask

  task automatic send32(input logic [31:0] v, input bit gap);
    for (int i = 0; i < 4; i++) begin
      if (gap) repeat ($urandom_range(0, 2)) @(negedge clk);
      send(v[8*i +: 8]);
    end
  endtask

  task automatic send_word(input string tag, input logic [31:0] v, input logic [15:0] addr, input bit gap);
    send32(v, gap);
    check({tag, "_we"}, 32'(o_im_we), 32'd1);
    check({tag, "_addr"}, 32'(o_im_waddr), 32'(addr));
    check({tag, "_data"}, o_im_wdata, v);
  endtask

  task automatic pulse_start;
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ready"}, 32'(o_byte_ready), 32'd0);
    check({tag, "_we"}, 32'(o_im_we), 32'd0);
    check({tag, "_waddr"}, 32'(o_im_waddr), 32'd0);
    check({tag, "_wdata"}, o_im_wdata, 32'd0);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_done"}, 32'(o_done), 32'd0);
    check({tag, "_err"}, 32'(o_err), 32'd0);
    check({tag, "_hold"}, 32'(o_cpu_rst_hold), 32'd1);
  endtask

  task automatic check_end(input string tag, input bit ok);
    check({tag, "_done"}, 32'(o_done), 32'(ok));
    check({tag, "_err"}, 32'(o_err), 32'(!ok));
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_hold"}, 32'(o_cpu_rst_hold), 32'(!ok));
    check({tag, "_ready"}, 32'(o_byte_ready), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_reset("rst");
    rst = 1'b0;
    @(negedge clk);
    i_byte_valid = 1'b1;
    i_byte_data  = 8'hAA;
    repeat (3) begin
      @(negedge clk);
      check("idle_ready", 32'(o_byte_ready), 32'd0);
    end
    i_byte_valid = 1'b0;
    check("idle_nowr", 32'(nw), 32'd0);
    pulse_start;
    check("hdr_busy", 32'(o_busy), 32'd1);
    check("hdr_ready", 32'(o_byte_ready), 32'd1);
    check("hdr_hold", 32'(o_cpu_rst_hold), 32'd1);
    send(8'h02);
    send(8'h00);
    send_word("img_w0", 32'h00300413, 16'h0000, 1'b0);
    pulse_start;
    check("start_mid_busy", 32'(o_busy), 32'd1);
    send_word("img_w1", 32'h00100493, 16'h0004, 1'b0);
`ifdef IM_LOADER_CHECKSUM_EN
    send32(32'h004008A6, 1'b0);
`endif
    check_end("img", 1'b1);
    check("img_nw", 32'(nw), 32'd2);
    pulse_start;
    check("restart_done_clr", 32'(o_done), 32'd0);
    send(8'h00);
    send(8'h00);
    check_end("n0", 1'b0);
    check("n0_nw", 32'(nw), 32'd2);
    pulse_start;
    send(8'h41);
    send(8'h00);
    check_end("n65", 1'b0);
    check("n65_nw", 32'(nw), 32'd2);
    pulse_start;
    send(8'h02);
    send(8'h00);
    send_word("mid_w0", 32'h00300413, 16'h0000, 1'b0);
    send(8'h93);
    send(8'h04);
    rst = 1'b1;
    #1;
    check_reset("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_rst_nw", 32'(nw), 32'd3);
    check("mid_rst_hold", 32'(o_cpu_rst_hold), 32'd1);
    pulse_start;
    send(8'h02);
    send(8'h00);
    send_word("rl_w0", 32'h00300413, 16'h0000, 1'b0);
    send_word("rl_w1", 32'h00100493, 16'h0004, 1'b0);
`ifdef IM_LOADER_CHECKSUM_EN
    send32(32'h004008A6, 1'b0);
`endif
    check_end("rl", 1'b1);
    check("rl_nw", 32'(nw), 32'd5);
    pulse_start;
    send(8'h40);
    send(8'h00);
    sum = 32'd0;
    for (int i = 0; i < 64; i++) begin
      w = {8'(i), ~8'(i), 8'(i * 3), 8'(i + 7)};
      sum = sum + w;
      send_word("gap_w", w, 16'(i * 4), 1'b1);
    end
`ifdef IM_LOADER_CHECKSUM_EN
    send32(sum, 1'b1);
`endif
    check_end("gap", 1'b1);
    check("gap_nw", 32'(nw), 32'd69);
    check("gap_lastaddr", 32'(o_im_waddr), 32'h0FC);
    pulse_start;
    send(8'h01);
    send(8'h00);
    send_word("n1_w0", 32'hFFF00893, 16'h0000, 1'b0);
`ifdef IM_LOADER_CHECKSUM_EN
    send32(32'hFFF00893, 1'b0);
`endif
    check_end("n1", 1'b1);
    check("n1_nw", 32'(nw), 32'd70);
`ifdef IM_LOADER_CHECKSUM_EN
    pulse_start;
    send(8'h01);
    send(8'h00);
    send_word("bad_w0", 32'hFFF00893, 16'h0000, 1'b0);
    send32(32'h00000000, 1'b0);
    check_end("bad_chk", 1'b0);
    check("bad_chk_nw", 32'(nw), 32'd71);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
